// File: rtl/sram_async_ctrl.sv
// Single-beat request front end for a 32-bit asynchronous SRAM with programmable wait states.
// Optional access counters are enabled with SRAM_ASYNC_CTRL_STATS_EN.
module sram_async_ctrl #(
    parameter int RD_WAIT_CYC  = 7,
    parameter int WR_PULSE_CYC = 6
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SRAM_ASYNC_CTRL_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
`endif
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [21:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [21:0] sram_addr,
    inout  wire  [31:0] sram_data,
    output logic [3:0]  sram_bsel_n,
    output logic        sram_cs_n,
    output logic        sram_wr_n,
    output logic        sram_oe_n
);

    typedef enum logic [2:0] {
        IDLE, RD_ACC, RD_TURN, WR_SETUP, WR_PULSE, WR_HOLD
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT_CYC - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_PULSE_CYC - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;
    logic [21:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_bsel_n;
    logic        r_cs_n;
    logic        r_wr_n;
    logic        r_oe_n;
    logic        r_drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_bsel_n    <= 4'hF;
            r_cs_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_drive     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_ready <= 1'b0;
                        r_addr  <= req_addr;
                        r_cs_n  <= 1'b0;
                        if (req_we) begin
                            r_state  <= WR_SETUP;
                            r_wdata  <= req_wdata;
                            r_bsel_n <= ~req_be;
                            r_drive  <= 1'b1;
                        end else begin
                            r_state  <= RD_ACC;
                            r_bsel_n <= 4'h0;
                            r_oe_n   <= 1'b0;
                            r_cnt    <= RD_LOAD;
                        end
                    end
                end
                RD_ACC: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= RD_TURN;
                        r_rdata     <= sram_data;
                        r_rsp_valid <= 1'b1;
                        r_cs_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RD_TURN: begin
                    r_state  <= IDLE;
                    r_ready  <= 1'b1;
                    r_bsel_n <= 4'hF;
                end
                WR_SETUP: begin
                    r_state <= WR_PULSE;
                    r_wr_n  <= 1'b0;
                    r_cnt   <= WR_LOAD;
                end
                WR_PULSE: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= WR_HOLD;
                        r_wr_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    r_state  <= IDLE;
                    r_ready  <= 1'b1;
                    r_cs_n   <= 1'b1;
                    r_drive  <= 1'b0;
                    r_bsel_n <= 4'hF;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_ASYNC_CTRL_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    // rsp_valid is high while the FSM sits in the completion state of that access type
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (stats_clr) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_rsp_valid) begin
            if (r_state == RD_TURN && r_rd_count != 16'hFFFF)
                r_rd_count <= r_rd_count + 16'd1;
            if (r_state == WR_HOLD && r_wr_count != 16'hFFFF)
                r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

    assign sram_data   = r_drive ? r_wdata : 32'hzzzz_zzzz;
    assign req_ready   = r_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign sram_addr   = r_addr;
    assign sram_bsel_n = r_bsel_n;
    assign sram_cs_n   = r_cs_n;
    assign sram_wr_n   = r_wr_n;
    assign sram_oe_n   = r_oe_n;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: SRAM device models, bus monitor and a byte-merge reference memory.
// Build with SRAM_ASYNC_CTRL_STATS_EN to also exercise the access counters.
module tb_sram_async_ctrl;

    localparam int RDW = 7;
    localparam int WRP = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vld_d = 1'b0, vld_f = 1'b0;
    logic        we = 1'b0;
    logic [21:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;

    logic        rdy_d, rsp_d, cs_d, wr_d, oe_d;
    logic [31:0] rdat_d;
    logic [21:0] sa_d;
    logic [3:0]  bs_d;
    wire  [31:0] sd_d;

    logic        rdy_f, rsp_f, cs_f, wr_f, oe_f;
    logic [31:0] rdat_f;
    logic [21:0] sa_f;
    logic [3:0]  bs_f;
    wire  [31:0] sd_f;

`ifdef SRAM_ASYNC_CTRL_STATS_EN
    logic        clr = 1'b0;
    logic [15:0] rdc_d, wrc_d, rdc_f, wrc_f;
`endif

    sram_async_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SRAM_ASYNC_CTRL_STATS_EN
        .stats_clr(clr), .rd_count(rdc_d), .wr_count(wrc_d),
`endif
        .req_valid(vld_d), .req_ready(rdy_d), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .rsp_valid(rsp_d), .rsp_rdata(rdat_d),
        .sram_addr(sa_d), .sram_data(sd_d), .sram_bsel_n(bs_d),
        .sram_cs_n(cs_d), .sram_wr_n(wr_d), .sram_oe_n(oe_d)
    );

    sram_async_ctrl #(.RD_WAIT_CYC(1), .WR_PULSE_CYC(1)) u_fast (
        .clk(clk), .rst_n(rst_n),
`ifdef SRAM_ASYNC_CTRL_STATS_EN
        .stats_clr(clr), .rd_count(rdc_f), .wr_count(wrc_f),
`endif
        .req_valid(vld_f), .req_ready(rdy_f), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .rsp_valid(rsp_f), .rsp_rdata(rdat_f),
        .sram_addr(sa_f), .sram_data(sd_f), .sram_bsel_n(bs_f),
        .sram_cs_n(cs_f), .sram_wr_n(wr_f), .sram_oe_n(oe_f)
    );

    logic [31:0] mem_d [256];
    logic [31:0] mem_f [256];
    logic [31:0] ref_d [256];
    logic [31:0] ref_f [256];

    // Device drives read data under cs/oe; a zero keeper holds the bus while deselected
    assign sd_d = (!cs_d && !oe_d) ? mem_d[sa_d[7:0]] :
                  (cs_d ? 32'h0 : 32'hzzzz_zzzz);
    assign sd_f = (!cs_f && !oe_f) ? mem_f[sa_f[7:0]] :
                  (cs_f ? 32'h0 : 32'hzzzz_zzzz);

    always @(negedge clk) begin
        if (!cs_d && !wr_d)
            for (int i = 0; i < 4; i++)
                if (!bs_d[i]) mem_d[sa_d[7:0]][8*i +: 8] = sd_d[8*i +: 8];
        if (!cs_f && !wr_f)
            for (int i = 0; i < 4; i++)
                if (!bs_f[i]) mem_f[sa_f[7:0]][8*i +: 8] = sd_f[8*i +: 8];
    end

    int          mon_err = 0;
    int          cs_low = 0;
    int          wr_low = 0;
    logic [3:0]  mon_bsel = 4'hA;
    logic        p_cs = 1'b1, p_oe = 1'b1;
    logic [21:0] p_a = '0;
    logic [3:0]  p_bs = '0;
    logic [31:0] p_sd = '0;

    always @(negedge clk) begin
        if (!cs_d) cs_low++;
        if (!wr_d) begin
            wr_low++;
            mon_bsel = bs_d;
        end
        if (cs_d && sd_d !== 32'h0) mon_err++;
        if (!oe_d && !wr_d) mon_err++;
        if (!cs_d && !p_cs && (sa_d !== p_a || bs_d !== p_bs || oe_d !== p_oe))
            mon_err++;
        if (!cs_d && !p_cs && oe_d && p_oe && sd_d !== p_sd) mon_err++;
        p_cs = cs_d; p_oe = oe_d; p_a = sa_d; p_bs = bs_d; p_sd = sd_d;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input bit f, input bit w, input logic [21:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output int lat, output logic [31:0] rd, output logic ra);
        int n;
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b;
        if (f) vld_f = 1'b1; else vld_d = 1'b1;
        n = 0;
        while (!(f ? rdy_f : rdy_d) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        vld_d = 1'b0; vld_f = 1'b0;
        cs_low = 0; wr_low = 0; mon_bsel = 4'hA;
        lat = 0; ra = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) ra = f ? rdy_f : rdy_d;
        end while (!(f ? rsp_f : rsp_d) && lat < 60);
        rd = f ? rdat_f : rdat_d;
    endtask

    task automatic op(input bit f, input bit w, input logic [21:0] a,
                      input logic [31:0] d, input logic [3:0] b, input string tag);
        int lat;
        logic [31:0] rd, exp;
        logic ra;
        exp = w ? 32'h0 : (f ? ref_f[a[7:0]] : ref_d[a[7:0]]);
        do_req(f, w, a, d, b, lat, rd, ra);
        chk({tag, "_lat"}, 32'(lat), f ? (w ? 32'd3 : 32'd2) : (w ? 32'(WRP + 2) : 32'(RDW + 1)));
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_ready_drop"}, 32'(ra), 32'd0);
        if (w)
            for (int i = 0; i < 4; i++)
                if (b[i]) begin
                    if (f) ref_f[a[7:0]][8*i +: 8] = d[8*i +: 8];
                    else   ref_d[a[7:0]][8*i +: 8] = d[8*i +: 8];
                end
    endtask

    initial begin
        int n;
        int rsp_seen;
        logic [21:0] ra_;
        for (int i = 0; i < 256; i++) begin
            mem_d[i] = '0; mem_f[i] = '0; ref_d[i] = '0; ref_f[i] = '0;
        end

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy_d), 32'd1);
        chk("rst_rsp", 32'(rsp_d), 32'd0);
        chk("rst_rdata", rdat_d, 32'h0);
        chk("rst_addr", 32'(sa_d), 32'h0);
        chk("rst_bsel", 32'(bs_d), 32'hF);
        chk("rst_strobes", 32'({cs_d, wr_d, oe_d}), 32'h7);
        chk("rst_bus", sd_d, 32'h0);
        rst_n = 1'b1;

        op(0, 1, 22'h10, 32'hDEADBEEF, 4'hF, "wr1");
        @(negedge clk);
        chk("wr1_wr_low", 32'(wr_low), 32'(WRP));
        chk("wr1_cs_low", 32'(cs_low), 32'(WRP + 2));
        chk("wr1_bsel", 32'(mon_bsel), 32'h0);
        op(0, 0, 22'h10, 32'h0, 4'h0, "rd1");
        chk("rd1_const", rdat_d, 32'hDEADBEEF);

        op(0, 1, 22'h20, 32'h11223344, 4'hF, "wr2");
        op(0, 1, 22'h20, 32'hAABBCCDD, 4'b0101, "wr3");
        op(0, 0, 22'h20, 32'h0, 4'h0, "rd2");
        chk("rd2_const", rdat_d, 32'h11BB33DD);

        op(0, 1, 22'h20, 32'hFFFFFFFF, 4'h0, "wr_be0");
        @(negedge clk);
        chk("wr_be0_bsel", 32'(mon_bsel), 32'hF);
        op(0, 0, 22'h20, 32'h0, 4'h0, "rd_be0");

        @(negedge clk);
        we = 1'b0; addr = 22'h10; vld_d = 1'b1;
        n = 0;
        while (!rsp_d && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_rdata", rdat_d, 32'hDEADBEEF);
        we = 1'b1; addr = 22'h30; wdata = 32'h12345678; be = 4'hF;
        @(negedge clk);
        chk("b2b_gap", 32'({cs_d, oe_d, rdy_d}), 32'h7);
        @(posedge clk);
        #1 vld_d = 1'b0;
        @(negedge clk);
        chk("b2b_setup", 32'({cs_d, oe_d, wr_d}), 32'h3);
        n = 0;
        while (!rsp_d && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_wr_lat", 32'(n + 1), 32'(WRP + 2));
        ref_d[8'h30] = 32'h12345678;
        op(0, 0, 22'h30, 32'h0, 4'h0, "b2b_rd");
        chk("bus_monitor", 32'(mon_err), 32'd0);

        op(1, 1, 22'h05, 32'hCAFEF00D, 4'hF, "fast_wr");
        op(1, 0, 22'h05, 32'h0, 4'h0, "fast_rd");

        for (int k = 0; k < 24; k++) begin
            ra_ = 22'($urandom_range(0, 15));
            op(0, 1'($urandom_range(0, 1)), ra_, $urandom, 4'($urandom_range(0, 15)), "rand");
        end
        chk("rand_monitor", 32'(mon_err), 32'd0);

        @(negedge clk);
        we = 1'b1; addr = 22'h40; wdata = 32'h0F0F0F0F; be = 4'hF; vld_d = 1'b1;
        n = 0;
        while (!rdy_d && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 vld_d = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_in_pulse", 32'({cs_d, wr_d}), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({cs_d, wr_d, oe_d}), 32'h7);
        chk("abort_bus", sd_d, 32'h0);
        chk("abort_ready", 32'(rdy_d), 32'd1);
        rsp_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_d) rsp_seen++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (rsp_d) rsp_seen++;
        end
        chk("abort_no_rsp", 32'(rsp_seen), 32'd0);
        chk("abort_ready_after", 32'(rdy_d), 32'd1);
        ref_d[8'h40] = 32'h0F0F0F0F;

`ifdef SRAM_ASYNC_CTRL_STATS_EN
        chk("stats_rst_rd", 32'(rdc_d), 32'd0);
        chk("stats_rst_wr", 32'(wrc_d), 32'd0);
        op(0, 0, 22'h1, 32'h0, 4'h0, "st_r");
        op(0, 1, 22'h2, 32'h01020304, 4'hF, "st_w");
        op(0, 0, 22'h2, 32'h0, 4'h0, "st_r");
        op(0, 1, 22'h3, 32'h05060708, 4'h3, "st_w");
        op(0, 0, 22'h3, 32'h0, 4'h0, "st_r");
        @(negedge clk);
        chk("stats_rd3", 32'(rdc_d), 32'd3);
        chk("stats_wr2", 32'(wrc_d), 32'd2);
        op(0, 0, 22'h1, 32'h0, 4'h0, "st_clr");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("stats_clr_rd", 32'(rdc_d), 32'd0);
        chk("stats_clr_wr", 32'(wrc_d), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
